pid_core_param: RTL and testbench

//  Parametrised, multi-cycle PID controller core; successor to the fixed 8-bit tt_um_pid_controller datapath.

---
 rtl/pid_core_param.sv | 236 +++++++++++++++++++++++
 tb/tb_pid_core_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pid_core_param.sv
// Multi-cycle PID controller core: one shared multiplier, clamped integrator, saturating output.
// Build option: define PID_ANTIWINDUP_EN to hold the integrator while the output is saturated toward the error.
module pid_core_param #(
    parameter int unsigned W       = 8,
    parameter int unsigned GW      = 8,
    parameter int unsigned FRAC    = 4,
    parameter int unsigned INT_LIM = 1023,
    parameter int unsigned BIAS    = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_valid,
    input  logic [W-1:0]  setpoint,
    input  logic [W-1:0]  feedback,
    input  logic [GW-1:0] kp,
    input  logic [GW-1:0] ki,
    input  logic [GW-1:0] kd,
    input  logic          clear,
    output logic          busy,
    output logic          out_valid,
    output logic [W-1:0]  control_out,
    output logic          sat_hi,
    output logic          sat_lo,
    output logic          overrun
);
    localparam int unsigned EW = W + 1;
    localparam int unsigned DW = W + 2;
    localparam int unsigned IW = $clog2(INT_LIM + 1) + 1;
    localparam int unsigned SW = ((IW > EW) ? IW : EW) + 1;
    localparam int unsigned MW = (IW > DW) ? IW : DW;
    localparam int unsigned PW = GW + 1 + MW;
    localparam int unsigned AW = PW + 2;
    localparam int unsigned OW = ((AW > 32) ? AW : 32) + 1;

    localparam logic signed [SW-1:0] LIM_HI  = SW'(INT_LIM);
    localparam logic signed [SW-1:0] LIM_LO  = -LIM_HI;
    localparam logic signed [OW-1:0] BIAS_S  = OW'(BIAS);
    localparam logic signed [OW-1:0] OUT_MAX = OW'({W{1'b1}});
    localparam logic [W-1:0] RST_OUT =
        (64'(BIAS) > ((64'd1 << W) - 64'd1)) ? {W{1'b1}} : W'(BIAS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ERR   = 3'd1;
    localparam logic [2:0] S_MUL_P = 3'd2;
    localparam logic [2:0] S_MUL_I = 3'd3;
    localparam logic [2:0] S_MUL_D = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    logic [2:0]           state, state_n;
    logic [W-1:0]         sp_r, sp_n, fb_r, fb_n;
    logic [GW-1:0]        kp_r, kp_n, ki_r, ki_n, kd_r, kd_n;
    logic signed [EW-1:0] e_r, e_n, e_prev, e_prev_n;
    logic signed [DW-1:0] de_r, de_n;
    logic signed [IW-1:0] integ, integ_n;
    logic signed [AW-1:0] acc, acc_n;
    logic                 busy_n, out_valid_n, sat_hi_n, sat_lo_n, overrun_n;
    logic [W-1:0]         control_out_n;

    logic signed [EW-1:0] e_c;
    logic signed [DW-1:0] de_c;
    logic signed [SW-1:0] isum_c;
    logic signed [IW-1:0] iclamp_c;
    logic signed [GW:0]   op_a_c;
    logic signed [MW-1:0] op_b_c;
    logic signed [PW-1:0] prod_c;
    logic signed [AW-1:0] acc_shr_c;
    logic signed [OW-1:0] s_c;
    logic                 hold_c;

`ifdef PID_ANTIWINDUP_EN
    assign hold_c = (sat_hi && !e_c[EW-1] && (e_c != '0)) || (sat_lo && e_c[EW-1]);
`else
    assign hold_c = 1'b0;
`endif

    // Error, derivative, clamped integrator and the shared multiplier operand mux
    always_comb begin
        e_c    = $signed({1'b0, sp_r}) - $signed({1'b0, fb_r});
        de_c   = DW'(e_c) - DW'(e_prev);
        isum_c = SW'(integ) + SW'(e_c);
        if (isum_c > LIM_HI) begin
            iclamp_c = IW'(LIM_HI);
        end else if (isum_c < LIM_LO) begin
            iclamp_c = IW'(LIM_LO);
        end else begin
            iclamp_c = IW'(isum_c);
        end

        op_a_c = '0;
        op_b_c = '0;
        case (state)
            S_MUL_P: begin
                op_a_c = $signed({1'b0, kp_r});
                op_b_c = MW'(e_r);
            end
            S_MUL_I: begin
                op_a_c = $signed({1'b0, ki_r});
                op_b_c = MW'(integ);
            end
            S_MUL_D: begin
                op_a_c = $signed({1'b0, kd_r});
                op_b_c = MW'(de_r);
            end
            default: ;
        endcase
        prod_c    = PW'(op_a_c) * PW'(op_b_c);
        acc_shr_c = acc >>> FRAC;
        s_c       = OW'(acc_shr_c) + BIAS_S;
    end

    // Next-state and next-output logic; clear overrides everything else
    always_comb begin
        state_n       = state;
        sp_n          = sp_r;
        fb_n          = fb_r;
        kp_n          = kp_r;
        ki_n          = ki_r;
        kd_n          = kd_r;
        e_n           = e_r;
        de_n          = de_r;
        e_prev_n      = e_prev;
        integ_n       = integ;
        acc_n         = acc;
        busy_n        = busy;
        out_valid_n   = 1'b0;
        control_out_n = control_out;
        sat_hi_n      = sat_hi;
        sat_lo_n      = sat_lo;
        overrun_n     = overrun;

        if (clear) begin
            state_n   = S_IDLE;
            busy_n    = 1'b0;
            integ_n   = '0;
            e_prev_n  = '0;
            overrun_n = 1'b0;
        end else begin
            if (sample_valid && busy) begin
                overrun_n = 1'b1;
            end
            case (state)
                S_IDLE: begin
                    busy_n = 1'b0;
                    if (sample_valid && !busy) begin
                        sp_n    = setpoint;
                        fb_n    = feedback;
                        kp_n    = kp;
                        ki_n    = ki;
                        kd_n    = kd;
                        busy_n  = 1'b1;
                        state_n = S_ERR;
                    end
                end
                S_ERR: begin
                    e_n     = e_c;
                    de_n    = de_c;
                    integ_n = hold_c ? integ : iclamp_c;
                    state_n = S_MUL_P;
                end
                S_MUL_P: begin
                    acc_n   = AW'(prod_c);
                    state_n = S_MUL_I;
                end
                S_MUL_I: begin
                    acc_n   = acc + AW'(prod_c);
                    state_n = S_MUL_D;
                end
                S_MUL_D: begin
                    acc_n   = acc + AW'(prod_c);
                    state_n = S_OUT;
                end
                S_OUT: begin
                    // busy stays high through the out_valid cycle and drops in IDLE
                    if (s_c > OUT_MAX) begin
                        control_out_n = {W{1'b1}};
                        sat_hi_n      = 1'b1;
                        sat_lo_n      = 1'b0;
                    end else if (s_c < 0) begin
                        control_out_n = '0;
                        sat_hi_n      = 1'b0;
                        sat_lo_n      = 1'b1;
                    end else begin
                        control_out_n = W'(s_c);
                        sat_hi_n      = 1'b0;
                        sat_lo_n      = 1'b0;
                    end
                    e_prev_n    = e_r;
                    out_valid_n = 1'b1;
                    state_n     = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sp_r        <= '0;
            fb_r        <= '0;
            kp_r        <= '0;
            ki_r        <= '0;
            kd_r        <= '0;
            e_r         <= '0;
            de_r        <= '0;
            e_prev      <= '0;
            integ       <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            control_out <= RST_OUT;
            sat_hi      <= 1'b0;
            sat_lo      <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            sp_r        <= sp_n;
            fb_r        <= fb_n;
            kp_r        <= kp_n;
            ki_r        <= ki_n;
            kd_r        <= kd_n;
            e_r         <= e_n;
            de_r        <= de_n;
            e_prev      <= e_prev_n;
            integ       <= integ_n;
            acc         <= acc_n;
            busy        <= busy_n;
            out_valid   <= out_valid_n;
            control_out <= control_out_n;
            sat_hi      <= sat_hi_n;
            sat_lo      <= sat_lo_n;
            overrun     <= overrun_n;
        end
    end

endmodule

// File: tb/tb_pid_core_param.sv
// Bench for pid_core_param: vector table of samples, overrun and abort sequences,
// expected outputs queued on drive and popped when out_valid appears.
module tb_pid_core_param;
    logic       clk;
    logic       rst_n;
    logic       sample_valid;
    logic [7:0] setpoint, feedback, kp, ki, kd;
    logic       clear;
    logic       busy, out_valid, sat_hi, sat_lo, overrun;
    logic [7:0] control_out;

    typedef struct {
        logic [7:0] out;
        logic       hi;
        logic       lo;
    } exp_t;

    typedef struct {
        logic       clr;
        logic [7:0] sp, fb, kp, ki, kd, eo;
        logic       eh, el;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[13];
    int   n_checks = 0;
    int   n_fail   = 0;

    pid_core_param #(
        .W(8), .GW(8), .FRAC(4), .INT_LIM(1023), .BIAS(128)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sample_valid(sample_valid),
        .setpoint(setpoint),
        .feedback(feedback),
        .kp(kp),
        .ki(ki),
        .kd(kd),
        .clear(clear),
        .busy(busy),
        .out_valid(out_valid),
        .control_out(control_out),
        .sat_hi(sat_hi),
        .sat_lo(sat_lo),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Presents one sample for a single cycle; returns on the negedge after the accepting edge
    task automatic drive_sample(input string tag, input logic [7:0] sp, input logic [7:0] fb,
                                input logic [7:0] gp, input logic [7:0] gi, input logic [7:0] gd,
                                input logic [7:0] eo, input logic eh, input logic el);
        exp_t e;
        @(negedge clk);
        setpoint     = sp;
        feedback     = fb;
        kp           = gp;
        ki           = gi;
        kd           = gd;
        sample_valid = 1'b1;
        e.out = eo;
        e.hi  = eh;
        e.lo  = el;
        exp_q.push_back(e);
        @(negedge clk);
        sample_valid = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    endtask

    // Waits (bounded) for out_valid, checks latency, pops and compares the expected result
    task automatic wait_output(input string tag, input int start_edges);
        int   edges;
        exp_t e;
        edges = start_edges;
        while (!out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'd5);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_unexpected_out: got out_valid with empty queue, required none", tag);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_control_out"}, 32'(control_out), 32'(e.out));
                check({tag, "_sat_hi"}, 32'(sat_hi), 32'(e.hi));
                check({tag, "_sat_lo"}, 32'(sat_lo), 32'(e.lo));
                check({tag, "_busy_in_valid"}, 32'(busy), 32'd1);
            end
        end
        @(negedge clk);
        check({tag, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
        check({tag, "_busy_released"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;

        rst_n        = 1'b0;
        sample_valid = 1'b0;
        clear        = 1'b0;
        setpoint     = '0;
        feedback     = '0;
        kp           = '0;
        ki           = '0;
        kd           = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_control_out", 32'(control_out), 32'd128);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sat_hi", 32'(sat_hi), 32'd0);
        check("reset_sat_lo", 32'(sat_lo), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;

        //           clr   sp    fb    kp    ki    kd    out   hi    lo
        vecs[0]  = '{1'b1, 8'd100, 8'd80, 8'd16, 8'd0, 8'd0, 8'd148, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8'd10, 8'd0, 8'd0, 8'd16, 8'd0, 8'd138, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'd10, 8'd0, 8'd0, 8'd16, 8'd0, 8'd148, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'd10, 8'd0, 8'd0, 8'd16, 8'd0, 8'd158, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'd10, 8'd0, 8'd0, 8'd0, 8'd16, 8'd138, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'd30, 8'd0, 8'd0, 8'd0, 8'd16, 8'd148, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'd200, 8'd0, 8'd0, 8'd16, 8'd0, 8'd255, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'd200, 8'd0, 8'd0, 8'd16, 8'd0, 8'd255, 1'b1, 1'b0};
`ifdef PID_ANTIWINDUP_EN
        vecs[10] = '{1'b0, 8'd0, 8'd100, 8'd0, 8'd16, 8'd0, 8'd228, 1'b0, 1'b0};
`else
        vecs[10] = '{1'b0, 8'd0, 8'd100, 8'd0, 8'd16, 8'd0, 8'd255, 1'b1, 1'b0};
`endif
        // Mixed gains, negative error: -290 >>> 4 floors to -19
        vecs[11] = '{1'b1, 8'd50, 8'd60, 8'd17, 8'd8, 8'd4, 8'd109, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'd60, 8'd50, 8'd17, 8'd8, 8'd4, 8'd143, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].clr) pulse_clear();
            drive_sample($sformatf("row%0d", i), vecs[i].sp, vecs[i].fb, vecs[i].kp,
                         vecs[i].ki, vecs[i].kd, vecs[i].eo, vecs[i].eh, vecs[i].el);
            wait_output($sformatf("row%0d", i), 0);
        end

        // Overrun: a second request while busy is dropped and flagged
        pulse_clear();
        drive_sample("ovr", 8'd100, 8'd80, 8'd16, 8'd0, 8'd0, 8'd148, 1'b0, 1'b0);
        @(negedge clk);
        setpoint     = 8'd200;
        feedback     = 8'd0;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("ovr_flag_set", 32'(overrun), 32'd1);
        wait_output("ovr", 2);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("ovr_single_output", 32'(pulses), 32'd0);
        check("ovr_flag_sticky", 32'(overrun), 32'd1);

        // Abort: clear while the integral term is being multiplied
        @(negedge clk);
        setpoint     = 8'd10;
        feedback     = 8'd0;
        kp           = 8'd0;
        ki           = 8'd16;
        kd           = 8'd0;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("abort_no_output", 32'(pulses), 32'd0);
        check("abort_control_out_kept", 32'(control_out), 32'd148);
        check("abort_overrun_cleared", 32'(overrun), 32'd0);
        check("abort_busy_low", 32'(busy), 32'd0);
        drive_sample("post_abort", 8'd10, 8'd0, 8'd0, 8'd16, 8'd0, 8'd138, 1'b0, 1'b0);
        wait_output("post_abort", 0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
